alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 8-bit datapath ALU.
- Registers result and flags (carry, zero), so carry chains across instructions via a new add-with-carry op.
- Executes shifts iteratively, one bit per cycle, under a start/busy/done handshake.
- Sits between the register file read ports and the writeback mux; the controller stalls the PC while busy is high.

Parameters:
WIDTH, 8, datapath width in bits (legal: 4..32).
CNT_W, $clog2(WIDTH+2), width of the internal shift-iteration counter.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  request; sampled only in IDLE
alu_cmd  in  3  opcode (op_t), sampled with start
inA  in  WIDTH  operand A, sampled with start
inB  in  WIDTH  operand B or signed shift immediate, sampled with start
sc_clr  in  1  clear carry flag (honoured when no op completes that cycle)
busy  out  1  high while an accepted op is executing
done  out  1  one-cycle pulse when rslt/flags update
rslt  out  WIDTH  registered result, held until next completion
sc_o  out  1  registered carry/borrow/shift-out flag
zero  out  1  registered (rslt == 0) flag

Behaviour:
- Reset values: busy=0, done=0, rslt=0, sc_o=0, zero=0, state=IDLE, counter=0.
- Reset mid-operation: the op is abandoned and the block is in IDLE with reset values on the next edge; no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE + start, non-shift op: compute and register rslt/sc_o/zero, go to DONE. done=1 in the cycle after start (latency 1). busy stays 0.
- IDLE + start, SHIFT op: load acc=inA and counter, go to SHIFT with busy=1.
- SHIFT: each cycle shift acc one bit in the decided direction. sc_o takes the bit shifted out. Counter decrements.
- SHIFT exit: on the cycle counter reaches 1, register rslt/zero and go to DONE.
- Shift latency: k iterations means busy for k cycles; done asserts k+1 cycles after start.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start seen in DONE is ignored.
- start while busy or in DONE: ignored, with no queueing.
- Opcodes and results (carry noted per op):
  - ADD: {c,r} = A+B, carry-in 0.
  - ADC: {c,r} = A+B+sc_o (registered flag).
  - SUB: {c,r} = A−B, c = borrow (A<B unsigned).
  - BXOR: A^B, c=0.
  - AND: A&B, c=0.
  - RXOR: {WIDTH−1 zeros, ^A}, c=0.
  - NOT: ~A, c=0.
  - SHIFT: see shift encoding below.
- Shift encoding (inB as signed WIDTH-bit):
  - inB<0: left shift by −inB.
  - inB>=0: right logical shift by inB+1.
  - Amount range is 1..2^(WIDTH−1).
  - Iterations are capped at WIDTH+1; any amount ≥ WIDTH+1 gives rslt=0, sc_o=0.
  - Amount exactly WIDTH: rslt=0, sc_o = the original end bit (MSB for left, LSB for right).
- Widths: all arithmetic is WIDTH+1 bits; the MSB goes to the carry.
- zero is computed from the registered result value, never from the pre-update value.
- sc_clr:
  - Clears sc_o on the next edge unless an op completes that same edge; completion wins.
  - sc_clr together with start of ADC in IDLE: ADC uses the old flag, and the result overwrites it.
- Flags update only on completion (the DONE transition edge). During SHIFT, sc_o/rslt keep their previous values; acc is internal.

Decomposition:
- Package definitions gains:
  - op_t enum: kADD=0, kADC=1, kSHIFT=2, kBXOR=3, kAND=4, kRXOR=5, kSUB=6, kNOT=7.
  - alu_state_t enum {IDLE, SHIFT, DONE}.
- Sub-module alu_shift_step: combinational one-bit left/right step returning {next_acc, out_bit}, parametrised by WIDTH. The FSM, counter and flag registers stay in alu_seq.

Test Plan:
- WIDTH=8. ADD A=0xF0,B=0x20 -> done at cycle 1, rslt=0x10, sc_o=1, zero=0. Then ADC A=0x01,B=0x01 -> rslt=0x03, sc_o=0.
- SHIFT A=0x81,B=0xFF (left 1) -> busy 1 cycle, done at cycle 2, rslt=0x02, sc_o=1. SHIFT A=0x05,B=0x00 (right 1) -> rslt=0x02, sc_o=1.
- SHIFT A=0xFF,B=0x7F (right 128) -> capped, busy 9 cycles, done at cycle 10, rslt=0x00, sc_o=0, zero=1. SHIFT A=0x80,B=0xF8 (left 8) -> rslt=0x00, sc_o=1.
- SUB 0x03−0x05 -> rslt=0xFE, sc_o=1. SUB 0x05−0x05 -> rslt=0x00, sc_o=0, zero=1.
- RXOR A=0x07 -> rslt=0x01, sc_o=0. NOT A=0x00 -> rslt=0xFF. With sc_o=1, pulse sc_clr alone, then ADC 0x01+0x01 -> rslt=0x02.
- During a left-by-5 shift: assert start with ADD at cycle 2 -> ignored, shift result unchanged. Assert reset at cycle 3 -> cycle 4 busy=0, done=0, rslt=0, sc_o=0, and no later done pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        kADD   = 3'd0,
        kADC   = 3'd1,
        kSHIFT = 3'd2,
        kBXOR  = 3'd3,
        kAND   = 3'd4,
        kRXOR  = 3'd5,
        kSUB   = 3'd6,
        kNOT   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_shift_step.sv
// One-bit logical shift step: left or right by one, reporting the bit that falls off.
module alu_shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             left,
    output logic [WIDTH-1:0] next_acc,
    output logic             out_bit
);

    always_comb begin
        if (left) begin
            next_acc = {acc[WIDTH-2:0], 1'b0};
            out_bit  = acc[WIDTH-1];
        end else begin
            next_acc = {1'b0, acc[WIDTH-1:1]};
            out_bit  = acc[0];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle arithmetic/logic ops with registered flags,
// and iterative one-bit-per-cycle shifts under a start/busy/done handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sc_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rslt,
    output logic             sc_o,
    output logic             zero
);

    localparam int MAX_IT = WIDTH + 1;

    alu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, step_acc;
    logic             step_out, shl, end_bit, exact_w;
    logic [WIDTH:0]   amt, res;
    logic             accept, is_shift, shift_last;

    assign accept     = (state == IDLE) && start;
    assign is_shift   = (alu_cmd == kSHIFT);
    assign shift_last = (state == SHIFT) && (cnt == CNT_W'(1));

    // inB is a signed immediate: negative means left by -inB, else right by inB+1
    assign amt = inB[WIDTH-1] ? ({1'b0, ~inB} + 1'b1) : ({1'b0, inB} + 1'b1);

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .left     (shl),
        .next_acc (step_acc),
        .out_bit  (step_out)
    );

    always_comb begin
        res = '0;
        case (alu_cmd)
            kADD:    res = {1'b0, inA} + {1'b0, inB};
            kADC:    res = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, sc_o};
            kSUB:    res = {1'b0, inA} - {1'b0, inB};
            kBXOR:   res = {1'b0, inA ^ inB};
            kAND:    res = {1'b0, inA & inB};
            kRXOR:   res = {{WIDTH{1'b0}}, ^inA};
            kNOT:    res = {1'b0, ~inA};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = is_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            shl     <= 1'b0;
            end_bit <= 1'b0;
            exact_w <= 1'b0;
            rslt    <= '0;
            sc_o    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if (accept && is_shift) begin
                acc     <= inA;
                shl     <= inB[WIDTH-1];
                // a full-width shift reports the original end bit, not the last one out
                end_bit <= inB[WIDTH-1] ? inA[WIDTH-1] : inA[0];
                exact_w <= (int'(amt) == WIDTH);
                cnt     <= (int'(amt) > MAX_IT) ? CNT_W'(MAX_IT) : amt[CNT_W-1:0];
            end else if (state == SHIFT) begin
                acc <= step_acc;
                cnt <= cnt - 1'b1;
            end

            if (accept && !is_shift) begin
                rslt <= res[WIDTH-1:0];
                sc_o <= res[WIDTH];
                zero <= (res[WIDTH-1:0] == '0);
            end else if (shift_last) begin
                rslt <= step_acc;
                sc_o <= exact_w ? end_bit : step_out;
                zero <= (step_acc == '0);
            end else if (sc_clr) begin
                sc_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: inputs driven and outputs sampled on the falling edge.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, sc_clr;
    op_t          alu_cmd;
    logic [W-1:0] inA, inB;
    logic         busy, done;
    logic [W-1:0] rslt;
    logic         sc_o, zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_cmd (alu_cmd),
        .inA     (inA),
        .inB     (inB),
        .sc_clr  (sc_clr),
        .busy    (busy),
        .done    (done),
        .rslt    (rslt),
        .sc_o    (sc_o),
        .zero    (zero)
    );

    // Issue one op and wait (bounded) for done; lat = falling edges from start to done.
    task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic clr, output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; alu_cmd = op; inA = a; inB = b; sc_clr = clr;
        @(negedge clk);
        start = 1'b0; sc_clr = 1'b0;
        lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sc_clr = 1'b0; alu_cmd = kADD; inA = '0; inB = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (rslt !== 8'h00) begin n_bad++; $display("FAIL reset_rslt got=%h exp=00", rslt); end
        n_cmp++; if (sc_o !== 1'b0) begin n_bad++; $display("FAIL reset_sc got=%b exp=0", sc_o); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got=%b exp=0", zero); end
        reset = 1'b0;
    endtask

    task automatic test_add_adc();
        int lat, nb;
        run_op(kADD, 8'hF0, 8'h20, 1'b0, lat, nb);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
        n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL add_busy got=%0d exp=0", nb); end
        n_cmp++; if (rslt !== 8'h10) begin n_bad++; $display("FAIL add_rslt got=%h exp=10", rslt); end
        n_cmp++; if (sc_o !== 1'b1) begin n_bad++; $display("FAIL add_sc got=%b exp=1", sc_o); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got=%b exp=0", zero); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got=%b exp=0", done); end
        run_op(kADC, 8'h01, 8'h01, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'h03) begin n_bad++; $display("FAIL adc_rslt got=%h exp=03", rslt); end
        n_cmp++; if (sc_o !== 1'b0) begin n_bad++; $display("FAIL adc_sc got=%b exp=0", sc_o); end
    endtask

    task automatic test_shift();
        int lat, nb;
        run_op(kSHIFT, 8'h81, 8'hFF, 1'b0, lat, nb);
        n_cmp++; if (nb != 1 || lat != 2) begin n_bad++; $display("FAIL shl1_timing got busy=%0d lat=%0d exp busy=1 lat=2", nb, lat); end
        n_cmp++; if (rslt !== 8'h02 || sc_o !== 1'b1) begin n_bad++; $display("FAIL shl1 got=%h/%b exp=02/1", rslt, sc_o); end
        run_op(kSHIFT, 8'h05, 8'h00, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'h02 || sc_o !== 1'b1) begin n_bad++; $display("FAIL shr1 got=%h/%b exp=02/1", rslt, sc_o); end
        run_op(kSHIFT, 8'hFF, 8'h7F, 1'b0, lat, nb);
        n_cmp++; if (nb != 9 || lat != 10) begin n_bad++; $display("FAIL shr128_timing got busy=%0d lat=%0d exp busy=9 lat=10", nb, lat); end
        n_cmp++; if (rslt !== 8'h00 || sc_o !== 1'b0 || zero !== 1'b1) begin n_bad++; $display("FAIL shr128 got=%h/%b/%b exp=00/0/1", rslt, sc_o, zero); end
        run_op(kSHIFT, 8'h80, 8'hF8, 1'b0, lat, nb);
        n_cmp++; if (nb != 8) begin n_bad++; $display("FAIL shl8_busy got=%0d exp=8", nb); end
        n_cmp++; if (rslt !== 8'h00 || sc_o !== 1'b1) begin n_bad++; $display("FAIL shl8 got=%h/%b exp=00/1", rslt, sc_o); end
    endtask

    task automatic test_sub();
        int lat, nb;
        run_op(kSUB, 8'h03, 8'h05, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'hFE || sc_o !== 1'b1 || zero !== 1'b0) begin n_bad++; $display("FAIL sub_borrow got=%h/%b/%b exp=FE/1/0", rslt, sc_o, zero); end
        run_op(kSUB, 8'h05, 8'h05, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'h00 || sc_o !== 1'b0 || zero !== 1'b1) begin n_bad++; $display("FAIL sub_equal got=%h/%b/%b exp=00/0/1", rslt, sc_o, zero); end
    endtask

    task automatic test_logic();
        int lat, nb;
        run_op(kRXOR, 8'h07, 8'h00, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'h01 || sc_o !== 1'b0) begin n_bad++; $display("FAIL rxor got=%h/%b exp=01/0", rslt, sc_o); end
        run_op(kNOT, 8'h00, 8'h00, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'hFF) begin n_bad++; $display("FAIL not got=%h exp=FF", rslt); end
        run_op(kBXOR, 8'hA5, 8'h0F, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'hAA) begin n_bad++; $display("FAIL bxor got=%h exp=AA", rslt); end
        run_op(kAND, 8'hA5, 8'h0F, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'h05) begin n_bad++; $display("FAIL and got=%h exp=05", rslt); end
    endtask

    task automatic test_sc_clr();
        int lat, nb;
        run_op(kSUB, 8'h03, 8'h05, 1'b0, lat, nb);
        @(negedge clk); sc_clr = 1'b1;
        @(negedge clk); sc_clr = 1'b0;
        n_cmp++; if (sc_o !== 1'b0 || rslt !== 8'hFE) begin n_bad++; $display("FAIL clr_alone got=%h/%b exp=FE/0", rslt, sc_o); end
        run_op(kADC, 8'h01, 8'h01, 1'b0, lat, nb);
        n_cmp++; if (rslt !== 8'h02) begin n_bad++; $display("FAIL adc_after_clr got=%h exp=02", rslt); end
        run_op(kSUB, 8'h03, 8'h05, 1'b0, lat, nb);
        run_op(kADC, 8'h01, 8'h01, 1'b1, lat, nb);
        n_cmp++; if (rslt !== 8'h03 || sc_o !== 1'b0) begin n_bad++; $display("FAIL adc_with_clr got=%h/%b exp=03/0", rslt, sc_o); end
        run_op(kADD, 8'hF0, 8'h20, 1'b1, lat, nb);
        n_cmp++; if (sc_o !== 1'b1) begin n_bad++; $display("FAIL clr_vs_complete got=%b exp=1", sc_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        @(negedge clk);
        start = 1'b1; alu_cmd = kADD; inA = 8'h01; inB = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[3-i] = done;
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (pat !== 4'b1010) begin n_bad++; $display("FAIL back_to_back got=%b exp=1010", pat); end
    endtask

    task automatic test_ignore_and_reset();
        int lat, nb, ndone;
        run_op(kADD, 8'h01, 8'h02, 1'b0, lat, nb);
        @(negedge clk);
        start = 1'b1; alu_cmd = kSHIFT; inA = 8'h01; inB = 8'hFB;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL shl5_busy got=%b exp=1", busy); end
        @(negedge clk);
        start = 1'b1; alu_cmd = kADD; inA = 8'h01; inB = 8'h01;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (rslt !== 8'h03 || busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL start_ignored got=%h/%b/%b exp=03/1/0", rslt, busy, done); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rslt !== 8'h00 || sc_o !== 1'b0 || zero !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset got=%b/%b/%h/%b/%b exp=0/0/00/0/0", busy, done, rslt, sc_o, zero);
        end
        reset = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL no_done_after_reset got=%0d exp=0", ndone); end
    endtask

    initial begin
        test_reset();
        test_add_adc();
        test_shift();
        test_sub();
        test_logic();
        test_sc_clr();
        test_back_to_back();
        test_ignore_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
